// File: rtl/house_pkg.sv
// Shared definitions for the house sorter control slice.
// House codes, FSM states and LFSR helpers.
package house_pkg;

  localparam logic [1:0] HOUSE_SLY = 2'd0;
  localparam logic [1:0] HOUSE_GRY = 2'd1;
  localparam logic [1:0] HOUSE_HUF = 2'd2;
  localparam logic [1:0] HOUSE_RAV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BROWSE = 2'd1,
    ST_SPIN   = 2'd2,
    ST_SORTED = 2'd3
  } state_e;

  // Taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s
  );
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  // Bit n set for house code n
  function automatic logic [3:0] house_onehot(
    input logic [1:0] h
  );
    return 4'b0001 << h;
  endfunction

endpackage

// File: rtl/house_sorter_key_debounce.sv
// Push-button synchroniser and debouncer.
// Emits one press pulse per accepted release->press change.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic i_rst,
  input  logic key_n,
  output logic o_level,
  output logic o_press
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_s;

  assign pressed_s = ~sync_q;

  // Count consecutive disagreeing cycles; accept on the last one
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (pressed_s != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = pressed_s;
        press_d = pressed_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, accepted level, counter and pulse registers
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= key_n;
      sync_q  <= meta_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_level = level_q;
  assign o_press = press_q;

endmodule

// File: rtl/house_sorter.sv
// Button-driven house selection for the VGA colour display.
// Flags only change on a vsync falling edge.
module house_sorter
  import house_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter int          CNT_W           = 18,
  parameter int          SPIN_FRAMES     = 60,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       key_next_n,
  input  logic       key_select_n,
  input  logic       key_rand_n,
  input  logic       key_clear_n,
  input  logic       i_vs,
  output logic       slytherin,
  output logic       gryffindor,
  output logic       hufflepuff,
  output logic       ravenclaw,
  output logic [1:0] o_state,
  output logic       o_sorted
);

  localparam logic [7:0] FRM_LAST = 8'(SPIN_FRAMES - 1);

  logic p_nxt, p_sel, p_rnd, p_clr;
  logic c_nxt, c_sel, c_rnd, c_clr;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_next (
    .clk    (clk),
    .i_rst  (i_rst),
    .key_n  (key_next_n),
    .o_level(),
    .o_press(p_nxt)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_select (
    .clk    (clk),
    .i_rst  (i_rst),
    .key_n  (key_select_n),
    .o_level(),
    .o_press(p_sel)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_rand (
    .clk    (clk),
    .i_rst  (i_rst),
    .key_n  (key_rand_n),
    .o_level(),
    .o_press(p_rnd)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_clear (
    .clk    (clk),
    .i_rst  (i_rst),
    .key_n  (key_clear_n),
    .o_level(),
    .o_press(p_clr)
  );

  // Coincident pulses: clear beats rand beats select beats next
  assign c_clr = p_clr;
  assign c_rnd = p_rnd & ~p_clr;
  assign c_sel = p_sel & ~p_rnd & ~p_clr;
  assign c_nxt = p_nxt & ~p_sel & ~p_rnd & ~p_clr;

  logic        vs_meta_q, vs_sync_q, vs_prev_q;
  logic        tick;
  logic [15:0] lfsr_q;

  assign tick = vs_prev_q & ~vs_sync_q;

  // Vsync synchroniser and free-running LFSR
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      vs_meta_q <= 1'b1;
      vs_sync_q <= 1'b1;
      vs_prev_q <= 1'b1;
      lfsr_q    <= LFSR_SEED;
    end else begin
      vs_meta_q <= i_vs;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
      lfsr_q    <= lfsr_step(lfsr_q);
    end
  end

  state_e     state_q, state_d;
  logic [1:0] pend_q, pend_d;
  logic [7:0] frm_q, frm_d;

  // Next-state and pending-house selection
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    frm_d   = frm_q;
    unique case (state_q)
      ST_IDLE: begin
        if (c_rnd) begin
          state_d = ST_SPIN;
          frm_d   = '0;
        end else if (c_nxt) begin
          state_d = ST_BROWSE;
          pend_d  = HOUSE_SLY;
        end
      end
      ST_BROWSE: begin
        if (c_clr) begin
          state_d = ST_IDLE;
        end else if (c_rnd) begin
          state_d = ST_SPIN;
          frm_d   = '0;
        end else if (c_sel) begin
          state_d = ST_SORTED;
        end else if (c_nxt) begin
          pend_d = pend_q + 2'd1;
        end
      end
      ST_SPIN: begin
        if (c_clr) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (frm_q == FRM_LAST) begin
            state_d = ST_SORTED;
            pend_d  = lfsr_q[1:0];
          end else begin
            pend_d = pend_q + 2'd1;
            frm_d  = frm_q + 8'd1;
          end
        end
      end
      ST_SORTED: begin
        if (c_clr) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, pending house and spin frame counter
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      pend_q  <= HOUSE_SLY;
      frm_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      frm_q   <= frm_d;
    end
  end

  logic       shown_vld_q;
  logic       shown_srt_q;
  logic [1:0] shown_house_q;
  logic [3:0] flags_q;
  logic       sorted_q;

  // Shown house is latched only at frame start
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      shown_vld_q   <= 1'b0;
      shown_srt_q   <= 1'b0;
      shown_house_q <= HOUSE_SLY;
    end else if (tick) begin
      shown_vld_q   <= (state_d != ST_IDLE);
      shown_srt_q   <= (state_d == ST_SORTED);
      shown_house_q <= pend_d;
    end
  end

  // Registered one-hot flags gated by the shown valid bit
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      flags_q  <= 4'b0000;
      sorted_q <= 1'b0;
    end else begin
      flags_q  <= shown_vld_q ? house_onehot(shown_house_q)
                              : 4'b0000;
      sorted_q <= shown_vld_q & shown_srt_q;
    end
  end

  assign slytherin  = flags_q[HOUSE_SLY];
  assign gryffindor = flags_q[HOUSE_GRY];
  assign hufflepuff = flags_q[HOUSE_HUF];
  assign ravenclaw  = flags_q[HOUSE_RAV];
  assign o_state    = state_q;
  assign o_sorted   = sorted_q;

endmodule
